tour_cmd_seq: RTL and testbench

TOUR_CMD_SEQ -- requirements
Module: tour_cmd_seq

---
 rtl/tour_cmd_seq.sv | 166 ++++++++++++++++
 tb/tb_tour_cmd_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd_seq.sv
// Command-tour sequencer: plays a small queue of command words over a command link and checks
// the intermediate/final acknowledge bytes that come back for each one.
module tour_cmd_seq #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned TMO_CLKS  = 1_000_000,
   parameter logic [7:0]  INTER_ACK = 8'h5A,
   parameter logic [7:0]  FINAL_ACK = 8'hA5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ld,
   input  logic [15:0]                ld_cmd,
   input  logic [1:0]                 ld_nresp,
   input  logic                       go,
   input  logic                       abort,
   input  logic                       clr,
   output logic [15:0]                cmd,
   output logic                       snd_cmd,
   input  logic                       cmd_snt,
   input  logic                       resp_rdy,
   input  logic [7:0]                 resp,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [1:0]                 err_code,
   output logic [$clog2(DEPTH)-1:0]   idx,
   output logic [$clog2(DEPTH):0]     cnt
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned TW = (TMO_CLKS > 1) ? $clog2(TMO_CLKS) : 1;
   localparam logic [IW:0]   CNT_MAX  = DEPTH[IW:0];
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CLKS - 1);
   localparam logic [IW-1:0] IDX_ZERO = '0;

   typedef enum logic [2:0] {StIdle, StSend, StWaitSnt, StWaitResp, StErr} state_e;

   state_e        state;
   logic [1:0]    rc;
   logic [TW-1:0] tmo;

   logic [15:0]   slot_cmd   [DEPTH];
   logic [1:0]    slot_nresp [DEPTH];

   logic          wr_en;
   logic [1:0]    cur_nresp;
   logic          last;
   logic          tmo_hit;
   logic [IW-1:0] idx_nxt;

   assign wr_en     = (state == StIdle) && ld && !clr && (cnt < CNT_MAX);
   assign cur_nresp = slot_nresp[idx];
   assign last      = ({1'b0, idx} == (cnt - 1'b1));
   assign tmo_hit   = (tmo == TMO_LAST);
   assign idx_nxt   = idx + 1'b1;

   assign busy = (state == StSend) || (state == StWaitSnt) || (state == StWaitResp);
   assign err  = (state == StErr);

   // Slot storage needs no reset: cnt alone decides which slots are valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         slot_cmd[cnt[IW-1:0]]   <= ld_cmd;
         slot_nresp[cnt[IW-1:0]] <= ld_nresp;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= StIdle;
         cnt      <= '0;
         idx      <= '0;
         rc       <= '0;
         tmo      <= '0;
         cmd      <= '0;
         snd_cmd  <= 1'b0;
         done     <= 1'b0;
         err_code <= 2'b00;
      end else begin
         snd_cmd <= 1'b0;
         done    <= 1'b0;
         case (state)
            StIdle: begin
               if (clr) begin
                  cnt <= '0;
               end else if (ld) begin
                  if (cnt < CNT_MAX) cnt <= cnt + 1'b1;
               end else if (go && (cnt != '0)) begin
                  idx     <= '0;
                  cmd     <= slot_cmd[IDX_ZERO];
                  snd_cmd <= 1'b1;
                  state   <= StSend;
               end
            end
            StSend: begin
               if (abort) begin
                  state    <= StErr;
                  err_code <= 2'b11;
               end else begin
                  state <= StWaitSnt;
                  tmo   <= '0;
               end
            end
            StWaitSnt: begin
               // Priority: abort, then the link event, then the timeout.
               if (abort) begin
                  state    <= StErr;
                  err_code <= 2'b11;
               end else if (cmd_snt) begin
                  state <= StWaitResp;
                  rc    <= '0;
                  tmo   <= '0;
               end else if (tmo_hit) begin
                  state    <= StErr;
                  err_code <= 2'b10;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            StWaitResp: begin
               if (abort) begin
                  state    <= StErr;
                  err_code <= 2'b11;
               end else if (resp_rdy) begin
                  tmo <= '0;
                  if (rc != cur_nresp) begin
                     if (resp == INTER_ACK) begin
                        rc <= rc + 1'b1;
                     end else begin
                        state    <= StErr;
                        err_code <= 2'b01;
                     end
                  end else if (resp != FINAL_ACK) begin
                     state    <= StErr;
                     err_code <= 2'b01;
                  end else if (last) begin
                     state <= StIdle;
                     done  <= 1'b1;
                     idx   <= '0;
                  end else begin
                     idx     <= idx_nxt;
                     cmd     <= slot_cmd[idx_nxt];
                     snd_cmd <= 1'b1;
                     state   <= StSend;
                  end
               end else if (tmo_hit) begin
                  state    <= StErr;
                  err_code <= 2'b10;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            StErr: begin
               if (clr) begin
                  state    <= StIdle;
                  err_code <= 2'b00;
                  cnt      <= '0;
                  idx      <= '0;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Bench for tour_cmd_seq: directed scenarios plus random tours, with the bench acting as the
// command link and a queue model of the loaded slots supplying every expected value.
module tb_tour_cmd_seq;

   localparam int unsigned D   = 4;
   localparam int unsigned TMO = 100;
   localparam logic [7:0]  IA  = 8'h5A;
   localparam logic [7:0]  FA  = 8'hA5;

   logic        clk, rst, ld, go, abort, clr, cmd_snt, resp_rdy;
   logic [15:0] ld_cmd, cmd;
   logic [1:0]  ld_nresp, err_code;
   logic [7:0]  resp;
   logic        snd_cmd, busy, done, err;
   logic [1:0]  idx;
   logic [2:0]  cnt;

   int n_cmp  = 0;
   int n_fail = 0;
   int snd_seen  = 0;
   int done_seen = 0;

   logic [15:0] mq_cmd [$];
   logic [1:0]  mq_n   [$];

   tour_cmd_seq #(
      .DEPTH    (D),
      .TMO_CLKS (TMO),
      .INTER_ACK(IA),
      .FINAL_ACK(FA)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .ld      (ld),
      .ld_cmd  (ld_cmd),
      .ld_nresp(ld_nresp),
      .go      (go),
      .abort   (abort),
      .clr     (clr),
      .cmd     (cmd),
      .snd_cmd (snd_cmd),
      .cmd_snt (cmd_snt),
      .resp_rdy(resp_rdy),
      .resp    (resp),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .err_code(err_code),
      .idx     (idx),
      .cnt     (cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pulse counters see the value held during the cycle that just ended.
   always @(posedge clk) begin
      if (snd_cmd === 1'b1) snd_seen++;
      if (done === 1'b1) done_seen++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [15:0] c, input logic [1:0] n);
      ld = 1'b1; ld_cmd = c; ld_nresp = n;
      tick();
      ld = 1'b0;
      if (mq_cmd.size() < D) begin
         mq_cmd.push_back(c);
         mq_n.push_back(n);
      end
   endtask

   task automatic clr_q();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      mq_cmd.delete();
      mq_n.delete();
   endtask

   task automatic wait_snd();
      int to = 0;
      while (snd_cmd !== 1'b1 && to < 20) begin
         tick();
         to++;
      end
      chk("snd_cmd_seen", {31'd0, snd_cmd}, 32'd1);
   endtask

   // Plays the model queue; bad_pos selects a global response index to corrupt (-1: none).
   task automatic play(input int bad_pos, input logic [7:0] bad_val);
      int s0, d0, gpos;
      logic [7:0] good;
      s0 = snd_seen; d0 = done_seen; gpos = 0;
      go = 1'b1;
      tick();
      go = 1'b0;
      for (int i = 0; i < mq_cmd.size(); i++) begin
         wait_snd();
         chk("cmd", {16'd0, cmd}, {16'd0, mq_cmd[i]});
         chk("idx", {30'd0, idx}, i);
         chk("busy_play", {31'd0, busy}, 32'd1);
         tick();
         chk("snd_one_cycle", {31'd0, snd_cmd}, 32'd0);
         repeat ($urandom_range(0, 3)) tick();
         cmd_snt = 1'b1;
         tick();
         cmd_snt = 1'b0;
         for (int r = 0; r <= int'(mq_n[i]); r++) begin
            repeat ($urandom_range(0, 3)) tick();
            good = (r < int'(mq_n[i])) ? IA : FA;
            resp_rdy = 1'b1;
            resp = good;
            if (gpos == bad_pos) resp = (bad_val == good) ? ~good : bad_val;
            tick();
            resp_rdy = 1'b0;
            if (gpos == bad_pos) begin
               chk("err_bad", {31'd0, err}, 32'd1);
               chk("code_bad", {30'd0, err_code}, 32'd1);
               chk("busy_bad", {31'd0, busy}, 32'd0);
               tick();
               chk("done_none", done_seen - d0, 32'd0);
               chk("snd_count_bad", snd_seen - s0, i + 1);
               return;
            end
            gpos++;
         end
      end
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("busy_end", {31'd0, busy}, 32'd0);
      chk("err_end", {31'd0, err}, 32'd0);
      chk("idx_end", {30'd0, idx}, 32'd0);
      tick();
      chk("done_once", done_seen - d0, 32'd1);
      chk("snd_count", snd_seen - s0, mq_cmd.size());
      chk("cnt_kept", {29'd0, cnt}, mq_cmd.size());
   endtask

   initial begin
      int s, n, tot, bad;
      rst = 1'b1; ld = 1'b0; go = 1'b0; abort = 1'b0; clr = 1'b0;
      cmd_snt = 1'b0; resp_rdy = 1'b0; resp = '0; ld_cmd = '0; ld_nresp = '0;
      repeat (2) tick();
      chk("rst_cnt", {29'd0, cnt}, 32'd0);
      chk("rst_idx", {30'd0, idx}, 32'd0);
      chk("rst_cmd", {16'd0, cmd}, 32'd0);
      chk("rst_snd", {31'd0, snd_cmd}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_code", {30'd0, err_code}, 32'd0);
      rst = 1'b0;
      tick();

      // Two-command tour with one intermediate ack on the first.
      load(16'h6020, 2'd1);
      load(16'h4001, 2'd0);
      chk("cnt_two", {29'd0, cnt}, 32'd2);
      play(-1, 8'h00);

      // Intermediate ack where the final ack was expected.
      clr_q();
      load(16'h1234, 2'd0);
      play(0, IA);
      ld = 1'b1; go = 1'b1; ld_cmd = 16'hFFFF;
      tick();
      ld = 1'b0; go = 1'b0;
      tick();
      chk("err_hold", {31'd0, err}, 32'd1);
      chk("err_ld_ign", {29'd0, cnt}, 32'd1);
      chk("err_go_ign", {31'd0, busy}, 32'd0);
      clr_q();
      chk("clr_err", {31'd0, err}, 32'd0);
      chk("clr_code", {30'd0, err_code}, 32'd0);
      chk("clr_cnt", {29'd0, cnt}, 32'd0);

      // Timeout fires exactly TMO cycles after cmd_snt.
      load(16'h0BAD, 2'd0);
      go = 1'b1; tick(); go = 1'b0;
      wait_snd();
      tick();
      cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
      repeat (TMO - 1) tick();
      chk("tmo_early", {31'd0, err}, 32'd0);
      tick();
      chk("tmo_err", {31'd0, err}, 32'd1);
      chk("tmo_code", {30'd0, err_code}, 32'd2);
      clr_q();

      // Response in the timeout cycle wins.
      load(16'h0C0D, 2'd0);
      go = 1'b1; tick(); go = 1'b0;
      wait_snd();
      tick();
      cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
      repeat (TMO - 1) tick();
      resp_rdy = 1'b1; resp = FA;
      tick();
      resp_rdy = 1'b0;
      chk("tmo_race_err", {31'd0, err}, 32'd0);
      chk("tmo_race_done", {31'd0, done}, 32'd1);

      // Overfill: extra load dropped, queue replayed twice.
      clr_q();
      for (int i = 0; i <= D; i++) load(16'($urandom), 2'($urandom_range(0, 3)));
      chk("cnt_full", {29'd0, cnt}, D);
      play(-1, 8'h00);
      play(-1, 8'h00);

      // Abort beats a same-cycle response.
      clr_q();
      load(16'hABCD, 2'd1);
      go = 1'b1; tick(); go = 1'b0;
      wait_snd();
      tick();
      cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
      abort = 1'b1; resp_rdy = 1'b1; resp = IA;
      tick();
      abort = 1'b0; resp_rdy = 1'b0;
      chk("abort_err", {31'd0, err}, 32'd1);
      chk("abort_code", {30'd0, err_code}, 32'd3);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      clr_q();
      chk("abort_clr_cnt", {29'd0, cnt}, 32'd0);
      chk("abort_clr_err", {31'd0, err}, 32'd0);
      load(16'h5555, 2'd0);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort_idle_err", {31'd0, err}, 32'd0);
      chk("abort_idle_cnt", {29'd0, cnt}, 32'd1);

      // Asynchronous reset while waiting for a response.
      clr_q();
      load(16'h7777, 2'd0);
      load(16'h8888, 2'd0);
      go = 1'b1; tick(); go = 1'b0;
      wait_snd();
      tick();
      cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_cmd", {16'd0, cmd}, 32'd0);
      chk("arst_cnt", {29'd0, cnt}, 32'd0);
      chk("arst_idx", {30'd0, idx}, 32'd0);
      chk("arst_err", {31'd0, err}, 32'd0);
      tick();
      rst = 1'b0;
      mq_cmd.delete();
      mq_n.delete();
      s = snd_seen;
      go = 1'b1; tick(); go = 1'b0;
      repeat (5) tick();
      chk("arst_go_busy", {31'd0, busy}, 32'd0);
      chk("arst_go_snd", snd_seen - s, 32'd0);

      // Random tours, some with a corrupted response.
      for (int it = 0; it < 20; it++) begin
         clr_q();
         n = $urandom_range(1, D);
         tot = 0;
         for (int k = 0; k < n; k++) begin
            load(16'($urandom), 2'($urandom_range(0, 3)));
            tot += int'(mq_n[k]) + 1;
         end
         chk("rnd_cnt", {29'd0, cnt}, n);
         bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, tot - 1)) : -1;
         play(bad, 8'($urandom));
         if (bad >= 0) begin
            clr_q();
            chk("rnd_clr_cnt", {29'd0, cnt}, 32'd0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
